// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable tick timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_e;

  // Prescaler period of the legacy ripple divider this block replaces
  localparam int unsigned DIV_DEFAULT_LEGACY = 62_500_000;

endpackage

// File: rtl/tick_prescaler.sv
// Programmable prescaler: holds the terminal count and the running pre-count,
// and flags the enabled cycle on which the count wraps back to zero.
module tick_prescaler #(
  parameter int          DIV_WIDTH   = 26,
  parameter int unsigned DIV_DEFAULT = timer_pkg::DIV_DEFAULT_LEGACY
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_count_en,
  input  logic [DIV_WIDTH-1:0] i_div_val,
  output logic                 o_wrap
);

  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_pre_cnt;
  logic [DIV_WIDTH-1:0] w_last;

  // A terminal count of 0 or 1 both mean "wrap on every enabled cycle"
  assign w_last = (r_div_q <= DIV_WIDTH'(1)) ? '0 : r_div_q - DIV_WIDTH'(1);
  assign o_wrap = i_count_en && !i_clear && (r_pre_cnt == w_last);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_div_q   <= DIV_WIDTH'(DIV_DEFAULT);
      r_pre_cnt <= '0;
    end else if (i_clear) begin
      r_div_q   <= i_div_val;
      r_pre_cnt <= '0;
    end else if (i_count_en) begin
      r_pre_cnt <= o_wrap ? '0 : r_pre_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/prog_tick_timer.sv
// Programmable tick timer: prescaled tick, toggling clk_out, and a tick counter
// that can lock into an EXPIRED state after a programmed number of ticks.
//
//   state      | meaning
//   ST_IDLE    | waiting for restart, counters and outputs held at 0
//   ST_RUN     | prescaler counting while enable is high
//   ST_EXPIRED | tick limit reached, everything held, expired=1
module prog_tick_timer
  import timer_pkg::*;
#(
  parameter int          DIV_WIDTH     = 26,
  parameter int unsigned DIV_DEFAULT   = DIV_DEFAULT_LEGACY,
  parameter int          T_WIDTH       = 8,
  parameter int unsigned LIMIT_DEFAULT = 0,
  parameter int          AUTO_START    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic [T_WIDTH-1:0]   limit_val,
  output logic                 tick,
  output logic                 clk_out,
  output logic [T_WIDTH-1:0]   tick_count,
  output logic                 expired
);

  localparam timer_state_e ST_RESET = (AUTO_START != 0) ? ST_RUN : ST_IDLE;

  timer_state_e        r_state;
  timer_state_e        w_state_nxt;
  logic [T_WIDTH-1:0]  r_limit_q;
  logic                r_tick;
  logic                r_clk_out;
  logic [T_WIDTH-1:0]  r_tick_count;
  logic                r_expired;

  logic                w_count_en;
  logic                w_wrap;
  logic                w_hit_limit;
  logic [T_WIDTH-1:0]  w_tick_count_inc;
  logic                w_tick_nxt;
  logic                w_clk_out_nxt;
  logic [T_WIDTH-1:0]  w_tick_count_nxt;
  logic                w_expired_nxt;

  assign w_count_en       = (r_state == ST_RUN) && enable;
  assign w_tick_count_inc = r_tick_count + T_WIDTH'(1);
  assign w_hit_limit      = (r_limit_q != '0) && (w_tick_count_inc == r_limit_q);

  tick_prescaler #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_prescaler (
    .clk_in     (clk_in),
    .rst        (rst),
    .i_clear    (restart),
    .i_count_en (w_count_en),
    .i_div_val  (div_val),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_limit_q    <= T_WIDTH'(LIMIT_DEFAULT);
      r_tick       <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick_count <= '0;
      r_expired    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick       <= w_tick_nxt;
      r_clk_out    <= w_clk_out_nxt;
      r_tick_count <= w_tick_count_nxt;
      r_expired    <= w_expired_nxt;
      if (restart) r_limit_q <= limit_val;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_wrap && w_hit_limit) w_state_nxt = ST_EXPIRED;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Restart wins over a coincident wrap, so the pending tick is dropped
  always_comb begin
    w_tick_nxt       = 1'b0;
    w_clk_out_nxt    = r_clk_out;
    w_tick_count_nxt = r_tick_count;
    w_expired_nxt    = r_expired;
    if (restart) begin
      w_clk_out_nxt    = 1'b0;
      w_tick_count_nxt = '0;
      w_expired_nxt    = 1'b0;
    end else if (w_wrap) begin
      w_tick_nxt       = 1'b1;
      w_clk_out_nxt    = ~r_clk_out;
      w_tick_count_nxt = w_tick_count_inc;
      if (w_hit_limit) w_expired_nxt = 1'b1;
    end
  end

  assign tick       = r_tick;
  assign clk_out    = r_clk_out;
  assign tick_count = r_tick_count;
  assign expired    = r_expired;

endmodule

// File: tb/tb_prog_tick_timer.sv
// Scoreboard bench for prog_tick_timer against an arithmetic reference model.
module tb_prog_tick_timer;

  localparam int DW   = 26;
  localparam int TW   = 8;
  localparam int DDEF = 4;
  localparam int LDEF = 0;
  localparam int AUTO = 1;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          restart = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] div_val = '0;
  logic [TW-1:0] limit_val = '0;
  logic          tick;
  logic          clk_out;
  logic [TW-1:0] tick_count;
  logic          expired;

  typedef struct packed {
    logic          tick;
    logic          clk_out;
    logic [TW-1:0] cnt;
    logic          expired;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Reference model: m_n counts enabled RUN cycles since restart/reset;
  // every output is derived from m_n and the effective divisor.
  longint m_n;
  int     m_div;
  int     m_limit;
  bit     m_run;
  bit     m_exp;
  bit     m_tick;

  prog_tick_timer #(
    .DIV_WIDTH     (DW),
    .DIV_DEFAULT   (DDEF),
    .T_WIDTH       (TW),
    .LIMIT_DEFAULT (LDEF),
    .AUTO_START    (AUTO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .restart    (restart),
    .enable     (enable),
    .div_val    (div_val),
    .limit_val  (limit_val),
    .tick       (tick),
    .clk_out    (clk_out),
    .tick_count (tick_count),
    .expired    (expired)
  );

  always #5 clk_in = ~clk_in;

  function automatic int eff_div();
    return (m_div <= 1) ? 1 : m_div;
  endfunction

  function automatic exp_t model_out();
    exp_t   e;
    longint ticks;
    ticks     = m_n / eff_div();
    e.tick    = m_tick;
    e.clk_out = ticks[0];
    e.cnt     = ticks[TW-1:0];
    e.expired = m_exp;
    return e;
  endfunction

  task automatic model_reset();
    m_n = 0; m_div = DDEF; m_limit = LDEF;
    m_run = (AUTO != 0); m_exp = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit rs, input bit en, input int dv, input int lv);
    if (r) begin
      model_reset();
    end else if (rs) begin
      m_div = dv; m_limit = lv; m_n = 0;
      m_run = 1'b1; m_exp = 1'b0; m_tick = 1'b0;
    end else if (m_run && !m_exp && en) begin
      m_n++;
      m_tick = ((m_n % eff_div()) == 0);
      if (m_limit != 0 && (m_n / eff_div()) >= m_limit) m_exp = 1'b1;
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic drive(input bit r, input bit rs, input bit en, input int dv, input int lv);
    @(negedge clk_in);
    rst       = r;
    restart   = rs;
    enable    = en;
    div_val   = DW'(dv);
    limit_val = TW'(lv);
    model_step(r, rs, en, dv, lv);
    exp_q.push_back(model_out());
  endtask

  // Reset raised mid-cycle must clear outputs before any clock edge
  task automatic pulse_rst_async();
    @(negedge clk_in);
    restart = 1'b0;
    enable  = 1'b1;
    #2 rst  = 1'b1;
    #1;
    n_tests++;
    if ({tick, clk_out, tick_count, expired} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: actual tick=%0b clk_out=%0b cnt=%0d expired=%0b, required all 0",
               tick, clk_out, tick_count, expired);
    end
    model_reset();
    exp_q.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {tick, clk_out, tick_count, expired};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_out @%0t: actual tick=%0b clk_out=%0b cnt=%0d expired=%0b, required tick=%0b clk_out=%0b cnt=%0d expired=%0b",
                   $time, a.tick, a.clk_out, a.cnt, a.expired, e.tick, e.clk_out, e.cnt, e.expired);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: actual run still active, required completion");
      $fatal(1, "timeout");
    end
  end

  initial begin : stimulus
    model_reset();
    repeat (2) drive(1, 0, 0, 0, 0);

    repeat (20) drive(0, 0, 1, 0, 0);

    while ((m_n % eff_div()) != 1) drive(0, 0, 1, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0);
    repeat (10) drive(0, 0, 1, 0, 0);

    drive(0, 1, 1, 3, 2);
    repeat (15) drive(0, 0, 1, 0, 0);

    pulse_rst_async();
    repeat (10) drive(0, 0, 1, 0, 0);

    while ((m_n % eff_div()) != eff_div() - 1) drive(0, 0, 1, 0, 0);
    drive(0, 1, 1, 4, 0);
    repeat (10) drive(0, 0, 1, 0, 0);

    drive(0, 1, 1, 0, 0);
    repeat (300) drive(0, 0, 1, 0, 0);

    pulse_rst_async();
    repeat (10) drive(0, 0, 1, 0, 0);

    repeat (2500) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 4) != 0), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
    end
    drive(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk_in);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
